// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - power-on cycle counter, staggered per-domain DUT reset and end-of-run flags
// Optional cycle timeout comparator is compiled in when RUN_SEQ_TIMEOUT_EN is defined.
module run_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int RESET_START = 1,
  parameter int RESET_LEN   = 1,
  parameter int NUM_DOMAINS = 1,
  parameter int STAGGER     = 0,
  parameter int TIMEOUT     = 10000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   finish_req,
  input  logic                   finish_ok,
  output logic [CNT_WIDTH-1:0]   cycle,
  output logic [NUM_DOMAINS-1:0] dut_reset,
  output logic                   running,
  output logic                   done,
  output logic                   passed,
  output logic                   timed_out
);

  // First cycle value past the reset window of domain idx.
  function automatic logic [63:0] window_end(input int idx);
    return 64'(RESET_START) + 64'(RESET_LEN) + 64'(idx) * 64'(STAGGER);
  endfunction

  localparam logic [63:0] CNT_MAX   = (CNT_WIDTH >= 64) ? {64{1'b1}} : ((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [63:0] WIN_START = 64'(RESET_START);
  localparam logic [63:0] RUN_START = window_end(NUM_DOMAINS - 1);

  // Parameter legality, caught at elaboration.
  if (CNT_WIDTH < 8 || CNT_WIDTH > 64) begin : g_bad_cnt_width
    $error("run_sequencer: CNT_WIDTH must be in 8..64");
  end
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_num_domains
    $error("run_sequencer: NUM_DOMAINS must be in 1..8");
  end
  if (RESET_START < 1 || RESET_LEN < 1 || STAGGER < 0 || TIMEOUT < 0) begin : g_bad_window
    $error("run_sequencer: RESET_START and RESET_LEN must be >= 1, STAGGER and TIMEOUT >= 0");
  end

  typedef enum logic [1:0] {PRE, RST, RUN, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   cycle_next;
  logic [63:0]            cycle_wide;
  logic [63:0]            cycle_next_wide;
  logic [NUM_DOMAINS-1:0] dut_reset_next;
  logic                   passed_next;
  logic                   timed_out_next;
  logic                   timeout_hit;

  assign cycle_wide      = 64'(cycle);
  assign cycle_next_wide = 64'(cycle_next);

`ifdef RUN_SEQ_TIMEOUT_EN
  // A timeout beyond the saturated count can never fire; legal but worth a warning.
  if (64'(TIMEOUT) > CNT_MAX) begin : g_timeout_unreachable
    $warning("run_sequencer: TIMEOUT exceeds counter range, timeout will never fire");
  end
  assign timeout_hit = (state == RUN) && (cycle_wide == 64'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Next counter value, next state, end-of-run verdict and next reset window.
  always_comb begin
    state_next     = state;
    cycle_next     = cycle;
    passed_next    = passed;
    timed_out_next = timed_out;
    dut_reset_next = '0;

    if (state != DONE && cycle_wide != CNT_MAX) begin
      cycle_next = cycle + CNT_WIDTH'(1);
    end

    case (state)
      PRE, RST: begin
        if (cycle_next_wide >= RUN_START) begin
          state_next = RUN;
        end else if (cycle_next_wide >= WIN_START) begin
          state_next = RST;
        end
      end
      RUN: begin
        if (finish_req || timeout_hit) begin
          state_next     = DONE;
          passed_next    = finish_req & finish_ok;
          timed_out_next = ~finish_req & timeout_hit;
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = PRE;
      end
    endcase

    // Window is evaluated on the count that will be presented alongside it.
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      dut_reset_next[i] = (cycle_next_wide >= WIN_START) && (cycle_next_wide < window_end(i));
    end
  end

  // Registered state and outputs; reset returns everything to the power-on view.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PRE;
      cycle     <= '0;
      dut_reset <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      passed    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_next;
      cycle     <= cycle_next;
      dut_reset <= dut_reset_next;
      running   <= (state_next == RUN);
      done      <= (state_next == DONE);
      passed    <= passed_next;
      timed_out <= timed_out_next;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized scoreboard bench for run_sequencer across four configurations
`timescale 1ns/1ps
module tb_run_sequencer;

  localparam int NB = 4;
`ifdef RUN_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] cyc;
    logic [7:0]  rst;
    logic        run;
    logic        done;
    logic        pass;
    logic        tmo;
  } obs_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks      = 0;
  int errors      = 0;
  int blocks_done = 0;

  for (genvar g = 0; g < NB; g++) begin : g_blk
    // Configuration and scripted events for this instance.
    localparam int     CW       = (g == 2) ? 8 : 32;
    localparam int     RS       = (g == 1) ? 4 : (g == 3) ? 2 : 1;
    localparam int     RL       = (g == 1) ? 2 : (g == 3) ? 3 : 1;
    localparam int     ND       = (g == 1) ? 3 : (g == 3) ? 4 : 1;
    localparam int     ST       = (g == 1) ? 3 : (g == 3) ? 2 : 0;
    localparam int     TO       = (g == 1) ? 100 : (g == 2) ? 255 : 10000;
    localparam longint FIN_AT   = (g == 0) ? (TO_EN ? -1 : 10050) : (g == 1) ? 100 : (g == 2) ? 300 : 50;
    localparam bit     FIN_OK   = (g == 1) ? 1'b0 : 1'b1;
    localparam longint FIN2_AT  = (g == 3) ? 60 : -1;
    localparam longint RST_AT   = (g == 0) ? 30 : -1;
    localparam int     BUDGET   = (g == 0) ? 10300 : 600;
    localparam longint MAXC     = (longint'(1) << CW) - 1;
    localparam longint END_LAST = RS + RL + (ND - 1) * ST;

    logic                   reset;
    logic                   finish_req;
    logic                   finish_ok;
    logic [CW-1:0]          cycle;
    logic [ND-1:0]          dut_reset;
    logic                   running;
    logic                   done;
    logic                   passed;
    logic                   timed_out;
    obs_t                   exp_q[$];

    run_sequencer #(
      .CNT_WIDTH  (CW),
      .RESET_START(RS),
      .RESET_LEN  (RL),
      .NUM_DOMAINS(ND),
      .STAGGER    (ST),
      .TIMEOUT    (TO)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .finish_req(finish_req),
      .finish_ok (finish_ok),
      .cycle     (cycle),
      .dut_reset (dut_reset),
      .running   (running),
      .done      (done),
      .passed    (passed),
      .timed_out (timed_out)
    );

    // Observable outputs implied by a cycle value and the end-of-run record.
    function automatic obs_t view(input longint c, input bit ended, input bit mp, input bit mt);
      obs_t o;
      o = '0;
      o.cyc = 64'(c);
      for (int i = 0; i < ND; i++) begin
        o.rst[i] = (c >= RS) && (c < longint'(RS + RL + i * ST));
      end
      o.run  = !ended && (c >= END_LAST);
      o.done = ended;
      o.pass = mp;
      o.tmo  = mt;
      return o;
    endfunction

    // Stimulus and reference model: t is elapsed clocks since reset release.
    initial begin : stim
      longint t, cf, cur;
      bit     ended, mp, mt, cur_run, hit, mid_done;
      int     n, post, rst_left;
      logic   rs, fr, ok;
      t = 0; cf = 0; ended = 0; mp = 0; mt = 0; mid_done = 0;
      n = 0; post = 0; rst_left = 0;
      reset = 1'b1; finish_req = 1'b0; finish_ok = 1'b0;
      while (n < BUDGET && post < 20) begin
        @(negedge clock);
        cur     = ended ? cf : ((t > MAXC) ? MAXC : t);
        cur_run = !ended && (cur >= END_LAST);
        if (RST_AT >= 0 && !mid_done && t == RST_AT) begin
          rst_left = 2;
          mid_done = 1;
        end
        rs = (n < 3) || (rst_left > 0);
        if (rst_left > 0) rst_left--;
        fr = (t == FIN_AT) || (t == FIN2_AT) ||
             (!cur_run && ((t == 1) || ($urandom_range(0, 1) == 1)));
        ok = (t == FIN2_AT) ? 1'b0 : (t == FIN_AT) ? FIN_OK : 1'($urandom_range(0, 1));
        hit = TO_EN && (cur == TO);
        if (rs) begin
          t = 0; ended = 0; cf = 0; mp = 0; mt = 0;
        end else begin
          if (cur_run && (fr || hit)) begin
            ended = 1;
            cf    = (cur + 1 > MAXC) ? MAXC : cur + 1;
            mp    = fr & ok;
            mt    = !fr && hit;
          end
          t++;
        end
        reset      = rs;
        finish_req = fr;
        finish_ok  = ok;
        exp_q.push_back(view(ended ? cf : ((t > MAXC) ? MAXC : t), ended, mp, mt));
        n++;
        if (ended) post++;
      end
      @(posedge clock);
      #2;
      blocks_done++;
    end

    // Monitor: pop one expectation per clock and compare against the DUT.
    initial begin : mon
      obs_t got, want;
      forever begin
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          got       = '0;
          got.cyc   = 64'(cycle);
          got.rst   = 8'(dut_reset);
          got.run   = running;
          got.done  = done;
          got.pass  = passed;
          got.tmo   = timed_out;
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL blk%0d outputs @%0t: got cyc=%0d rst=%b run=%b done=%b pass=%b tmo=%b, want cyc=%0d rst=%b run=%b done=%b pass=%b tmo=%b",
                     g, $time, got.cyc, got.rst, got.run, got.done, got.pass, got.tmo,
                     want.cyc, want.rst, want.run, want.done, want.pass, want.tmo);
          end
        end
      end
    end
  end

  // Wait for every instance to drain, bounded by a time limit.
  initial begin
    fork
      wait (blocks_done == NB);
      #400000;
    join_any
    if (blocks_done != NB) begin
      checks++;
      errors++;
      $display("FAIL watchdog: blocks finished %0d, required %0d", blocks_done, NB);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
